// File: rtl/arb_types.sv
// Shared types and widths for the I/D physical-memory arbiter.
package arb_types;

  localparam int LINE_WIDTH = 256;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } arb_state_t;

  typedef enum logic {
    ARB_I,
    ARB_D
  } arb_owner_t;

  // Busy state that serves the given owner.
  function automatic arb_state_t busy_state(input arb_owner_t owner);
    return (owner == ARB_D) ? D_BUSY : I_BUSY;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and shared memory port signals.
// master: the arbiter's view (drives the shared port and client responses).
// slave:  the surroundings' view (caches and physical memory).
interface mem_arbiter_if;
  import arb_types::*;

  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  modport master (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Arbiter control: state machine, winner selection and (optionally) the
// round-robin pointer. Optional feature macro: ARB_ROUND_ROBIN_EN.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | no command on the shared port; grant any pending request
//   I_BUSY | I-cache transaction in flight, waiting for mem_resp
//   D_BUSY | D-cache transaction in flight, waiting for mem_resp
module mem_arbiter_ctrl
  import arb_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic       d_read,
  input  logic       d_write,
  input  logic       mem_resp,
  output arb_state_t state,
  output logic       latch_en,
  output arb_owner_t grant_owner
);

  arb_state_t state_q;
  arb_state_t state_d;
  arb_owner_t winner;
  logic       d_req;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_grant_q;

  // Remember who was granted last; reset points at I so D wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= ARB_I;
    end else if (latch_en) begin
      last_grant_q <= winner;
    end
  end

  // On a tie the side not granted last wins; a lone requester always wins.
  always_comb begin
    winner = ARB_I;
    if (i_req && d_req) begin
      winner = (last_grant_q == ARB_D) ? ARB_I : ARB_D;
    end else if (d_req) begin
      winner = ARB_D;
    end
  end
`else
  // Fixed priority: D beats I on a tie.
  always_comb begin
    winner = d_req ? ARB_D : ARB_I;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and latch enable; requests only matter in IDLE.
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          latch_en = 1'b1;
          state_d  = busy_state(winner);
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state       = state_q;
  assign grant_owner = winner;

  // A D request with read and write both set is a client bug; write wins.
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(d_read && d_write))
    else $warning("mem_arbiter: D side drove read and write together");

endmodule

// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter onto one 256-bit line memory port.
// Holds the granted request in local registers so the shared port never
// follows live client inputs while a transaction is in flight.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie break).
module mem_arbiter
  import arb_types::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  arb_state_t            state;
  logic                  latch_en;
  arb_owner_t            grant_owner;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  read_q;
  logic                  write_q;
  logic                  busy;

  mem_arbiter_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .i_req      (bus.i_pmem_read),
    .d_read     (bus.d_pmem_read),
    .d_write    (bus.d_pmem_write),
    .mem_resp   (bus.mem_resp),
    .state      (state),
    .latch_en   (latch_en),
    .grant_owner(grant_owner)
  );

  // Capture the winner's request at grant; write has precedence on the D side.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else if (latch_en) begin
      if (grant_owner == ARB_D) begin
        addr_q  <= bus.d_pmem_address;
        wdata_q <= bus.d_pmem_wdata;
        write_q <= bus.d_pmem_write;
        read_q  <= bus.d_pmem_read & ~bus.d_pmem_write;
      end else begin
        addr_q  <= bus.i_pmem_address;
        wdata_q <= '0;
        write_q <= 1'b0;
        read_q  <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

  // Shared port is driven only from the holding registers.
  assign bus.mem_read    = busy & read_q;
  assign bus.mem_write   = busy & write_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;

  // Read data fans out to both clients; only the completion pulse is routed.
  assign bus.i_pmem_rdata = bus.mem_rdata;
  assign bus.d_pmem_rdata = bus.mem_rdata;
  assign bus.i_pmem_resp  = (state == I_BUSY) & bus.mem_resp;
  assign bus.d_pmem_resp  = (state == D_BUSY) & bus.mem_resp;

  // A memory completion with nothing outstanding is dropped.
  a_no_idle_resp: assert property (@(posedge clk) disable iff (rst)
    !(state == IDLE && bus.mem_resp))
    else $warning("mem_arbiter: mem_resp while idle ignored");

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus corner sequences,
// with a queue of expected memory commands checked as they appear.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic         is_d;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } exp_t;

  typedef struct {
    logic         i_rd;
    logic [31:0]  i_addr;
    logic         d_rd;
    logic         d_wr;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    int           lat;
    logic [255:0] line;
    logic         mangle;
  } vec_t;

  exp_t exp_q[$];
  exp_t cur;
  exp_t i_rec;
  exp_t d_rec;
  logic i_pend;
  logic d_pend;
  logic model_last_d;
  logic last_won_d;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[7];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_i();
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    i_pend             = 1'b0;
  endtask

  task automatic clear_d();
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    d_pend             = 1'b0;
  endtask

  task automatic req_i(input logic [31:0] addr);
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = addr;
    i_pend             = 1'b1;
    i_rec              = '{is_d: 1'b0, wr: 1'b0, addr: addr, wdata: '0};
  endtask

  task automatic req_d(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [255:0] wdata);
    bus.d_pmem_read    = rd;
    bus.d_pmem_write   = wr;
    bus.d_pmem_address = addr;
    bus.d_pmem_wdata   = wdata;
    d_pend             = 1'b1;
    d_rec              = '{is_d: 1'b1, wr: wr, addr: addr, wdata: wdata};
  endtask

  // Wait (bounded) for a command on the shared port and check it against
  // the oldest expected command.
  task automatic wait_cmd(output int w);
    w = 0;
    while (!(bus.mem_read || bus.mem_write) && w < 20) begin
      cyc();
      w++;
    end
    check("cmd_seen", bus.mem_read | bus.mem_write, 1'b1);
    if (exp_q.size() == 0) begin
      check("sb_nonempty", 1'b0, 1'b1);
      cur = '{is_d: 1'b0, wr: 1'b0, addr: '0, wdata: '0};
    end else begin
      cur = exp_q.pop_front();
    end
    check("cmd_write", bus.mem_write, cur.wr);
    check("cmd_read", bus.mem_read, !cur.wr);
    check("cmd_addr", bus.mem_address, cur.addr);
    if (cur.wr) check("cmd_wdata", bus.mem_wdata, cur.wdata);
  endtask

  // Hold the command for lat cycles, respond in the last one.
  task automatic serve(input int lat, input logic [255:0] line, input logic mangle);
    int   w;
    logic stable;
    wait_cmd(w);
    check("grant_latency", w, 1);
    stable = 1'b1;
    for (int j = 1; j <= lat; j++) begin
      if (mangle && j == 1) begin
        bus.d_pmem_address = 32'hFFFF_FFE0;
        bus.d_pmem_wdata   = ~cur.wdata;
      end
      if (j == lat) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = line;
      end
      @(negedge clk);
      if (bus.mem_read !== !cur.wr || bus.mem_write !== cur.wr ||
          bus.mem_address !== cur.addr || (cur.wr && bus.mem_wdata !== cur.wdata))
        stable = 1'b0;
      if (j < lat && (bus.i_pmem_resp || bus.d_pmem_resp)) stable = 1'b0;
      if (j == lat) begin
        check("i_resp", bus.i_pmem_resp, !cur.is_d);
        check("d_resp", bus.d_pmem_resp, cur.is_d);
        check("rdata_owner", cur.is_d ? bus.d_pmem_rdata : bus.i_pmem_rdata, line);
      end
      cyc();
    end
    bus.mem_resp = 1'b0;
    check("hold_stable", stable, 1'b1);
  endtask

  // Decide the winner from the bench's own priority model, queue its
  // expected command, serve it and release that client.
  task automatic grant_next(input int lat, input logic [255:0] line, input logic mangle);
    logic win_d;
    if (i_pend && d_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_d = !model_last_d;
`else
      win_d = 1'b1;
`endif
    end else begin
      win_d = d_pend;
    end
    exp_q.push_back(win_d ? d_rec : i_rec);
    model_last_d = win_d;
    last_won_d   = win_d;
    serve(lat, line, mangle && win_d);
    if (win_d) clear_d();
    else clear_i();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           w;
    logic         first;
    logic [3:0]   order;
    logic [255:0] line;

    vecs[0] = '{1'b1, 32'h0000_0060, 1'b0, 1'b0, 32'h0, '0, 5, {32{8'hA5}}, 1'b0};
    vecs[1] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_1000, {16{16'h1234}}, 3, {32{8'h3C}}, 1'b1};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_2000, '0, 1, {8{32'hDEAD_BEEF}}, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_4000, '0, 2, {8{32'h0BAD_F00D}}, 1'b0};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_5000, {8{32'hCAFE_0001}}, 2, {32{8'h5A}}, 1'b0};
    vecs[5] = '{1'b1, 32'hFFFF_FFE0, 1'b0, 1'b0, 32'h0, '0, 1, {64{4'h9}}, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_0080, {4{64'h0123_4567_89AB_CDEF}}, 4, {16{16'h7E81}}, 1'b0};

    rst           = 1'b1;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    clear_i();
    clear_d();
    model_last_d  = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    check("rst_mem_address", bus.mem_address, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 256'h0);
    check("rst_i_resp", bus.i_pmem_resp, 1'b0);
    check("rst_d_resp", bus.d_pmem_resp, 1'b0);
    cyc();
    rst = 1'b0;
    cyc();

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].i_rd) req_i(vecs[v].i_addr);
      if (vecs[v].d_rd || vecs[v].d_wr)
        req_d(vecs[v].d_rd, vecs[v].d_wr, vecs[v].d_addr, vecs[v].d_wdata);
      first = 1'b1;
      while (i_pend || d_pend) begin
        grant_next(vecs[v].lat, first ? vecs[v].line : ~vecs[v].line, vecs[v].mangle);
        first = 1'b0;
      end
      cyc();
    end

    // Completion while idle must not reach either client.
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {8{32'h1111_2222}};
    @(negedge clk);
    check("idle_resp_i", bus.i_pmem_resp, 1'b0);
    check("idle_resp_d", bus.d_pmem_resp, 1'b0);
    cyc();
    bus.mem_resp = 1'b0;
    check("idle_no_cmd", bus.mem_read | bus.mem_write, 1'b0);

    // Reset in the middle of a D read: command drops, no completion.
    req_d(1'b1, 1'b0, 32'h0000_9000, '0);
    exp_q.push_back(d_rec);
    wait_cmd(w);
    check("rstmid_latency", w, 1);
    cyc();
    rst = 1'b1;
    clear_d();
    cyc();
    check("rstmid_read", bus.mem_read, 1'b0);
    check("rstmid_write", bus.mem_write, 1'b0);
    bus.mem_resp = 1'b1;
    @(negedge clk);
    check("rstmid_resp", bus.i_pmem_resp | bus.d_pmem_resp, 1'b0);
    cyc();
    bus.mem_resp = 1'b0;
    rst          = 1'b0;
    model_last_d = 1'b0;
    cyc();

    req_i(32'h0000_0A00);
    grant_next(3, {8{32'h600D_0A00}}, 1'b0);
    cyc();
    model_last_d = 1'b0;

    // Both clients keep requesting; the served one reissues at once.
    // Reset the pointer first so the expected order is absolute.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    order = '0;
    req_i(32'h0000_7000);
    req_d(1'b1, 1'b0, 32'h0000_8000, '0);
    for (int g = 0; g < 4; g++) begin
      line = {8{g[31:0] ^ 32'hA0A0_0000}};
      grant_next(2, line, 1'b0);
      order = {order[2:0], last_won_d};
      if (g < 3) begin
        if (last_won_d) req_d(1'b1, 1'b0, 32'h0000_8000 + 32'(g + 1) * 32'h20, '0);
        else req_i(32'h0000_7000 + 32'(g + 1) * 32'h20);
      end
    end
`ifdef ARB_ROUND_ROBIN_EN
    check("collision_order", order, 4'b1010);
`else
    check("collision_order", order, 4'b1111);
`endif
    while (i_pend || d_pend) grant_next(1, {8{32'h5555_AAAA}}, 1'b0);
    cyc();

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
